// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker: pops wide words from a show-ahead FIFO and emits them as
// DATA_W/OUT_W narrow beats on a valid/ready stream, refilling back-to-back.
// Optional build macro FIFO_UNPACK_MSB_FIRST_EN: emit most-significant slice first
// (default, macro undefined: least-significant slice first).
module fifo_rd_unpacker #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned OUT_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   output logic              o_fifo_rden,
   input  logic [DATA_W-1:0] i_fifo_rddata,
   input  logic              i_fifo_empty,
   output logic              o_valid,
   output logic [OUT_W-1:0]  o_data,
   output logic              o_last,
   input  logic              i_ready
);

   localparam int unsigned RATIO = DATA_W / OUT_W;
   localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(RATIO - 1);

   // Reject configurations that cannot be split into at least two whole beats
   if ((RATIO < 2) || ((DATA_W % OUT_W) != 0)) begin : g_bad_cfg
      $error("fifo_rd_unpacker: DATA_W must be a multiple of OUT_W with ratio >= 2");
   end

   typedef enum logic {StIdle, StServe} state_e;

   state_e            state_q;
   logic [DATA_W-1:0] word_q;
   logic [CNT_W-1:0]  cnt_q;

   logic        is_last;
   logic        xfer;
   int unsigned sel;

   // Handshake decode and the combinational pop request
   always_comb begin
      is_last     = (cnt_q == CntLast);
      xfer        = (state_q == StServe) && i_ready;
      // Pop from idle, or on the final-beat transfer so the next word follows with no bubble
      o_fifo_rden = !i_fifo_empty && ((state_q == StIdle) || (xfer && is_last));
      o_valid     = (state_q == StServe);
      o_last      = o_valid && is_last;
   end

   // Slice selection for the current beat
   always_comb begin
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      sel = (RATIO - 1) - 32'(cnt_q);
`else
      sel = 32'(cnt_q);
`endif
      o_data = OUT_W'(word_q >> (sel * OUT_W));
   end

   // Control FSM: load a word, step through its slices, reload or go idle after the last
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         word_q  <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!i_fifo_empty) begin
                  word_q  <= i_fifo_rddata;
                  cnt_q   <= '0;
                  state_q <= StServe;
               end
            end
            StServe: begin
               if (i_ready) begin
                  if (!is_last) begin
                     cnt_q <= cnt_q + 1'b1;
                  end else if (!i_fifo_empty) begin
                     word_q <= i_fifo_rddata;
                     cnt_q  <= '0;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: a queue-based FIFO model feeds the DUT, and a
// beat scoreboard (filled with RATIO slices per popped word) predicts the stream.
module tb_fifo_rd_unpacker;

   localparam int DATA_W = 128;
   localparam int OUT_W  = 32;
   localparam int RATIO  = DATA_W / OUT_W;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic             l;
   } beat_t;

   logic              clk  = 1'b0;
   logic              rstn = 1'b1;
   logic              o_fifo_rden;
   logic [DATA_W-1:0] i_fifo_rddata;
   logic              i_fifo_empty;
   logic              o_valid;
   logic [OUT_W-1:0]  o_data;
   logic              o_last;
   logic              i_ready = 1'b0;

   logic [DATA_W-1:0] fifo_q[$];
   logic [DATA_W-1:0] garbage = '0;
   beat_t             exp_q[$];
   logic [OUT_W-1:0]  got_d[$];
   logic              got_l[$];

   int n_vec = 0;
   int n_err = 0;
   int pop_cnt = 0;
   int vld_cnt = 0;

   fifo_rd_unpacker #(
      .DATA_W(DATA_W),
      .OUT_W (OUT_W)
   ) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .o_fifo_rden  (o_fifo_rden),
      .i_fifo_rddata(i_fifo_rddata),
      .i_fifo_empty (i_fifo_empty),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_last       (o_last),
      .i_ready      (i_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Show-ahead FIFO pins: head word when non-empty, garbage otherwise
   task automatic upd_pins();
      i_fifo_empty  = (fifo_q.size() == 0);
      i_fifo_rddata = (fifo_q.size() == 0) ? garbage : fifo_q[0];
   endtask

   // Slice k of a word in emission order
   function automatic logic [OUT_W-1:0] slice_of(input logic [DATA_W-1:0] w, input int k);
      int idx;
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      idx = RATIO - 1 - k;
`else
      idx = k;
`endif
      return OUT_W'(w >> (idx * OUT_W));
   endfunction

   // Compare process: sample on negedge, apply predicted transfer/pop just after posedge
   initial begin
      logic p_pop, p_x, exp_rden, s_last;
      logic [OUT_W-1:0] s_data;
      logic [DATA_W-1:0] w;
      forever begin
         @(negedge clk);
         p_pop = 1'b0;
         p_x   = 1'b0;
         if (!rstn) begin
            exp_q.delete();
            chk("valid_in_reset", 128'(o_valid), 128'(0));
         end else begin
            exp_rden = !i_fifo_empty &&
                       ((exp_q.size() == 0) || ((exp_q.size() == 1) && i_ready));
            chk("rden", 128'(o_fifo_rden), 128'(exp_rden));
            chk("valid", 128'(o_valid), 128'(exp_q.size() != 0));
            if (o_valid && (exp_q.size() != 0)) begin
               chk("data", 128'(o_data), 128'(exp_q[0].d));
               chk("last", 128'(o_last), 128'(exp_q[0].l));
            end
            if (o_valid) vld_cnt++;
            s_data = o_data;
            s_last = o_last;
            p_pop  = o_fifo_rden && !i_fifo_empty;
            p_x    = o_valid && i_ready;
         end
         @(posedge clk);
         #1;
         if (rstn) begin
            if (p_x) begin
               got_d.push_back(s_data);
               got_l.push_back(s_last);
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (p_pop) begin
               w = fifo_q.pop_front();
               for (int k = 0; k < RATIO; k++) exp_q.push_back({slice_of(w, k), k == RATIO - 1});
               pop_cnt++;
               upd_pins();
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drain(input int budget, input logic rand_ready);
      int i = 0;
      while (((fifo_q.size() != 0) || (exp_q.size() != 0)) && (i < budget)) begin
         if (rand_ready) i_ready = 1'($urandom_range(0, 1));
         step(1);
         i++;
      end
      chk("drain_outstanding", 128'(exp_q.size() + fifo_q.size()), 128'(0));
      i_ready = 1'b1;
      step(2);
   endtask

   initial begin
      logic [DATA_W-1:0] w1;
      logic [OUT_W-1:0]  lit[4];
      int p0, v0;
      w1 = 128'h44444444_33333333_22222222_11111111;
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      lit[0] = 32'h44444444; lit[1] = 32'h33333333; lit[2] = 32'h22222222; lit[3] = 32'h11111111;
`else
      lit[0] = 32'h11111111; lit[1] = 32'h22222222; lit[2] = 32'h33333333; lit[3] = 32'h44444444;
`endif
      upd_pins();
      #1 rstn = 1'b0;
      #1;
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_data", 128'(o_data), 128'(0));
      chk("rst_last", 128'(o_last), 128'(0));
      chk("rst_rden", 128'(o_fifo_rden), 128'(0));
      step(2);
      rstn = 1'b1;
      step(2);

      // 1: single word, consumer always ready
      i_ready = 1'b1;
      got_d.delete(); got_l.delete();
      p0 = pop_cnt;
      fifo_q.push_back(w1); upd_pins();
      step(5);
      chk("t1_beats", 128'(got_d.size()), 128'(4));
      for (int k = 0; k < 4; k++) begin
         if (k < got_d.size()) begin
            chk("t1_data_lit", 128'(got_d[k]), 128'(lit[k]));
            chk("t1_last_lit", 128'(got_l[k]), 128'(k == 3));
         end
      end
      chk("t1_pops", 128'(pop_cnt - p0), 128'(1));
      step(1);
      chk("t1_idle_valid", 128'(o_valid), 128'(0));

      // 2: three words back-to-back, no bubbles
      got_d.delete(); got_l.delete();
      p0 = pop_cnt; v0 = vld_cnt;
      for (int n = 0; n < 3; n++) fifo_q.push_back({4{32'(32'hA0 + n)}} ^ 128'(n * 7 + 1));
      upd_pins();
      step(13);
      chk("t2_beats_13cyc", 128'(got_d.size()), 128'(12));
      chk("t2_pops", 128'(pop_cnt - p0), 128'(3));
      step(3);
      chk("t2_valid_cycles", 128'(vld_cnt - v0), 128'(12));

      // 3: random ready, four words
      got_d.delete(); got_l.delete();
      p0 = pop_cnt;
      for (int n = 0; n < 4; n++)
         fifo_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      upd_pins();
      drain(300, 1'b1);
      chk("t3_beats", 128'(got_d.size()), 128'(16));
      chk("t3_pops", 128'(pop_cnt - p0), 128'(4));

      // 4: empty FIFO with garbage on the data bus
      for (int c = 0; c < 20; c++) begin
         garbage = {$urandom(), $urandom(), $urandom(), $urandom()};
         upd_pins();
         step(1);
      end

      // 5: async reset after the second beat of a word
      got_d.delete(); got_l.delete();
      fifo_q.push_back(128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001); upd_pins();
      step(3);
      chk("t5_beats_before_rst", 128'(got_d.size()), 128'(2));
      #1 rstn = 1'b0;
      #1;
      chk("t5_valid_async", 128'(o_valid), 128'(0));
      chk("t5_last_async", 128'(o_last), 128'(0));
      step(2);
      rstn = 1'b1;
      step(6);
      chk("t5_beats_after_rst", 128'(got_d.size()), 128'(2));
      fifo_q.push_back(w1); upd_pins();
      drain(50, 1'b0);
      chk("t5_new_word_beats", 128'(got_d.size()), 128'(6));
      if (got_d.size() == 6) chk("t5_first_new", 128'(got_d[2]), 128'(lit[0]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
